// File: rtl/gelato_fetch_scheduler_rr.sv
// gelato_fetch_scheduler_rr: round-robin warp fetch scheduler sitting between
// the PC table and the instruction fetch unit.
//
// Each cycle one eligible warp (PC valid and not disabled) is chosen in
// round-robin order starting after the last issued warp. Its PC, warp number
// and split-table index are presented on a valid/ready channel. Once issued,
// a warp stays disabled until one of the ACT_PORTS activation channels
// re-enables it. On a handshake the next warp is loaded in the same cycle,
// so back-to-back issue has no bubble.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (applies regardless of rdy)
//   rdy             global enable; when low every register holds
//   pc_valid        per-warp PC valid bits
//   pc_flat         per-warp PCs, warp w at [w*PC_WIDTH +: PC_WIDTH]
//   split_flat      per-warp split-table index, same packing
//   act_valid       per-channel activation request
//   act_warp        per-channel warp index, channel k at [k*WARP_W +: WARP_W]
//   flush           drop the pending output and return to selection
//   out_valid/out_ready  issue handshake
//   out_pc, out_warp, out_split  issued warp information
//   disabled_mask   current per-warp disable bits
//   perf_issue_cnt  counted handshakes
//   perf_stall_cnt  cycles with out_valid held under backpressure
//
// Optional feature: define GELATO_FETCHSKD_PERF_EN to build the two
// performance counters; otherwise both perf ports are tied to zero.

module gelato_fetch_scheduler_rr #(
    parameter int WARP_NUM  = 32,
    parameter int WARP_W    = $clog2(WARP_NUM),
    parameter int PC_WIDTH  = 32,
    parameter int SPLIT_W   = 4,
    parameter int ACT_PORTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic [WARP_NUM-1:0]           pc_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]  pc_flat,
    input  logic [WARP_NUM*SPLIT_W-1:0]   split_flat,
    input  logic [ACT_PORTS-1:0]          act_valid,
    input  logic [ACT_PORTS*WARP_W-1:0]   act_warp,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_WIDTH-1:0]           out_pc,
    output logic [WARP_W-1:0]             out_warp,
    output logic [SPLIT_W-1:0]            out_split,
    output logic [WARP_NUM-1:0]           disabled_mask,
    output logic [31:0]                   perf_issue_cnt,
    output logic [31:0]                   perf_stall_cnt
);

    // Two-bit encoding leaves spare codes; they fall back to SELECT.
    localparam logic [1:0] S_SELECT = 2'b00;
    localparam logic [1:0] S_HOLD   = 2'b01;

    localparam logic [WARP_W-1:0] LAST_RST = WARP_W'(WARP_NUM - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [WARP_W-1:0]   warp_q;
    logic [WARP_W-1:0]   warp_d;
    logic [SPLIT_W-1:0]  split_q;
    logic [SPLIT_W-1:0]  split_d;
    logic [WARP_NUM-1:0] dis_q;
    logic [WARP_NUM-1:0] dis_d;
    logic [WARP_W-1:0]   last_q;
    logic [WARP_W-1:0]   last_d;

    // ------------------------------------------------------------------
    // Unpack the flat per-warp buses
    // ------------------------------------------------------------------
    logic [PC_WIDTH-1:0] pc_arr    [WARP_NUM];
    logic [SPLIT_W-1:0]  split_arr [WARP_NUM];

    for (genvar w = 0; w < WARP_NUM; w++) begin : g_unpack
        assign pc_arr[w]    = pc_flat[w*PC_WIDTH +: PC_WIDTH];
        assign split_arr[w] = split_flat[w*SPLIT_W +: SPLIT_W];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: rotate the request vector so that 'start' lands
    // at bit 0, take the lowest set bit, then rotate the index back.
    // The downward scan lets the lowest hit win without any early exit.
    // Result: {found, index}.
    // ------------------------------------------------------------------
    function automatic logic [WARP_W:0] rr_pick(
        input logic [WARP_NUM-1:0] req,
        input logic [WARP_W-1:0]   start
    );
        logic [2*WARP_NUM-1:0] dbl;
        logic [WARP_NUM-1:0]   rot;
        logic [WARP_W-1:0]     off;
        dbl = {req, req} >> start;
        rot = dbl[WARP_NUM-1:0];
        off = '0;
        for (int i = WARP_NUM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i[WARP_W-1:0];
            end
        end
        return {|rot, WARP_W'(start + off)};
    endfunction

    logic [WARP_NUM-1:0] elig;
    logic [WARP_NUM-1:0] held_oh;
    logic [WARP_W:0]     sel_res;
    logic [WARP_W:0]     nxt_res;
    logic                sel_found;
    logic                nxt_found;
    logic [WARP_W-1:0]   sel_idx;
    logic [WARP_W-1:0]   nxt_idx;

    assign elig    = pc_valid & ~dis_q;
    assign held_oh = WARP_NUM'(1) << warp_q;

    // Fresh selection continues after the last issued warp.
    assign sel_res   = rr_pick(elig, WARP_W'(last_q + 1'b1));
    // Zero-bubble follow-up excludes the warp being handed off right now.
    assign nxt_res   = rr_pick(elig & ~held_oh, WARP_W'(warp_q + 1'b1));

    assign sel_found = sel_res[WARP_W];
    assign sel_idx   = sel_res[WARP_W-1:0];
    assign nxt_found = nxt_res[WARP_W];
    assign nxt_idx   = nxt_res[WARP_W-1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SELECT;
            pc_q    <= '0;
            warp_q  <= '0;
            split_q <= '0;
            dis_q   <= '0;
            last_q  <= LAST_RST;
        end else if (rdy) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            warp_q  <= warp_d;
            split_q <= split_d;
            dis_q   <= dis_d;
            last_q  <= last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        warp_d  = warp_q;
        split_d = split_q;
        dis_d   = dis_q;
        last_d  = last_q;

        if (flush) begin
            // Pending output is dropped: no disable, pointer untouched.
            state_d = S_SELECT;
        end else begin
            case (state_q)
                S_SELECT: begin
                    if (sel_found) begin
                        state_d = S_HOLD;
                        warp_d  = sel_idx;
                        pc_d    = pc_arr[sel_idx];
                        split_d = split_arr[sel_idx];
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        dis_d[warp_q] = 1'b1;
                        last_d        = warp_q;
                        if (nxt_found) begin
                            warp_d  = nxt_idx;
                            pc_d    = pc_arr[nxt_idx];
                            split_d = split_arr[nxt_idx];
                        end else begin
                            state_d = S_SELECT;
                        end
                    end
                end
                default: begin
                    state_d = S_SELECT;
                end
            endcase
        end

        // Activations are applied last so they override a same-cycle disable.
        for (int k = 0; k < ACT_PORTS; k++) begin
            if (act_valid[k]) begin
                dis_d[act_warp[k*WARP_W +: WARP_W]] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        out_valid     = (state_q == S_HOLD);
        out_pc        = pc_q;
        out_warp      = warp_q;
        out_split     = split_q;
        disabled_mask = dis_q;
    end

`ifdef GELATO_FETCHSKD_PERF_EN
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        issue_hit;
    logic        stall_hit;

    assign issue_hit = rdy & out_valid & out_ready & ~flush;
    assign stall_hit = rdy & out_valid & ~out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue_hit) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end
            if (stall_hit) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_issue_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gelato_fetch_scheduler_rr.sv
// Directed self-checking bench for gelato_fetch_scheduler_rr.
// Expected values are hand-derived from the scheduler behaviour.

module tb_gelato_fetch_scheduler_rr;

    localparam int WN = 32;
    localparam int WW = 5;
    localparam int PW = 32;
    localparam int SW = 4;
    localparam int AP = 2;

`ifdef GELATO_FETCHSKD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              rdy;
    logic [WN-1:0]     pc_valid;
    logic [WN*PW-1:0]  pc_flat;
    logic [WN*SW-1:0]  split_flat;
    logic [AP-1:0]     act_valid;
    logic [AP*WW-1:0]  act_warp;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [PW-1:0]     out_pc;
    logic [WW-1:0]     out_warp;
    logic [SW-1:0]     out_split;
    logic [WN-1:0]     disabled_mask;
    logic [31:0]       perf_issue_cnt;
    logic [31:0]       perf_stall_cnt;

    int vectors;
    int miscompares;

    gelato_fetch_scheduler_rr dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .pc_valid       (pc_valid),
        .pc_flat        (pc_flat),
        .split_flat     (split_flat),
        .act_valid      (act_valid),
        .act_warp       (act_warp),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_warp       (out_warp),
        .out_split      (out_split),
        .disabled_mask  (disabled_mask),
        .perf_issue_cnt (perf_issue_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input int w);
        return 32'h1000 + 32'(w) * 32'd4;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        pc_valid  = '0;
        act_valid = '0;
        act_warp  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rdy         = 1'b1;
        for (int w = 0; w < WN; w++) begin
            pc_flat[w*PW +: PW]    = pc_of(w);
            split_flat[w*SW +: SW] = 4'(w);
        end
        do_reset();

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        chk("rst_warp", 32'(out_warp), 32'd0);
        chk("rst_split", 32'(out_split), 32'd0);
        chk("rst_dis", disabled_mask, 32'd0);
        chk("rst_issue", perf_issue_cnt, 32'd0);
        chk("rst_stall", perf_stall_cnt, 32'd0);

        // All warps eligible: 0..31 back to back, then idle
        pc_valid  = '1;
        out_ready = 1'b1;
        tick();
        chk("seq_first_valid", 32'(out_valid), 32'd1);
        chk("seq_first_warp", 32'(out_warp), 32'd0);
        for (int i = 1; i < WN; i++) begin
            tick();
            chk("seq_valid", 32'(out_valid), 32'd1);
            chk("seq_warp", 32'(out_warp), 32'(i));
            chk("seq_pc", out_pc, pc_of(i));
            chk("seq_split", 32'(out_split), 32'(i % 16));
            chk("seq_dis", disabled_mask, (32'd1 << i) - 32'd1);
        end
        tick();
        chk("seq_end_valid", 32'(out_valid), 32'd0);
        chk("seq_end_dis", disabled_mask, 32'hFFFF_FFFF);
        chk("seq_issue", perf_issue_cnt, PERF ? 32'd32 : 32'd0);

        // Warps 3 and 7 with activations one cycle after issue
        do_reset();
        pc_valid  = (32'd1 << 3) | (32'd1 << 7);
        out_ready = 1'b1;
        tick();
        chk("p37_a_warp", 32'(out_warp), 32'd3);
        chk("p37_a_valid", 32'(out_valid), 32'd1);
        tick();
        chk("p37_b_warp", 32'(out_warp), 32'd7);
        chk("p37_b_dis", disabled_mask, 32'd1 << 3);
        act_valid = 2'b01;
        act_warp  = {5'd0, 5'd3};
        tick();
        chk("p37_c_valid", 32'(out_valid), 32'd0);
        chk("p37_c_dis", disabled_mask, 32'd1 << 7);
        act_warp  = {5'd0, 5'd7};
        tick();
        chk("p37_d_valid", 32'(out_valid), 32'd1);
        chk("p37_d_warp", 32'(out_warp), 32'd3);
        chk("p37_d_dis", disabled_mask, 32'd0);
        act_valid = '0;
        tick();
        chk("p37_e_warp", 32'(out_warp), 32'd7);
        chk("p37_e_dis", disabled_mask, 32'd1 << 3);
        out_ready = 1'b0;

        // Hold warp 5 under backpressure while its inputs change
        do_reset();
        pc_valid = 32'd1 << 5;
        tick();
        chk("hold_start_warp", 32'(out_warp), 32'd5);
        pc_valid = '0;
        pc_flat[5*PW +: PW] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_warp", 32'(out_warp), 32'd5);
            chk("hold_pc", out_pc, pc_of(5));
        end
        chk("hold_stall", perf_stall_cnt, PERF ? 32'd4 : 32'd0);
        pc_flat[5*PW +: PW] = pc_of(5);
        out_ready = 1'b1;
        tick();
        chk("hold_done_valid", 32'(out_valid), 32'd0);
        chk("hold_done_dis", disabled_mask, 32'd1 << 5);
        chk("hold_issue", perf_issue_cnt, PERF ? 32'd1 : 32'd0);

        // Handshake on 9 with same-cycle activation of 9
        do_reset();
        pc_valid  = (32'd1 << 9) | (32'd1 << 10) | (32'd1 << 11);
        out_ready = 1'b1;
        tick();
        chk("act9_first", 32'(out_warp), 32'd9);
        act_valid = 2'b01;
        act_warp  = {5'd0, 5'd9};
        tick();
        chk("act9_dis", disabled_mask, 32'd0);
        chk("act9_next", 32'(out_warp), 32'd10);
        act_valid = '0;
        tick();
        chk("act9_w11", 32'(out_warp), 32'd11);
        tick();
        chk("act9_again", 32'(out_warp), 32'd9);
        chk("act9_again_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;

        // Flush with simultaneous handshake
        do_reset();
        pc_valid = (32'd1 << 2) | (32'd1 << 4);
        tick();
        chk("fl_warp", 32'(out_warp), 32'd2);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_dis", disabled_mask, 32'd0);
        chk("fl_issue", perf_issue_cnt, 32'd0);
        flush = 1'b0;
        tick();
        chk("fl_reissue_valid", 32'(out_valid), 32'd1);
        chk("fl_reissue_warp", 32'(out_warp), 32'd2);
        tick();
        chk("fl_next_warp", 32'(out_warp), 32'd4);
        chk("fl_next_dis", disabled_mask, 32'd1 << 2);

        // rdy low freezes everything, including activations and flush
        rdy       = 1'b0;
        act_valid = 2'b01;
        act_warp  = {5'd0, 5'd2};
        flush     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_valid", 32'(out_valid), 32'd1);
            chk("frz_warp", 32'(out_warp), 32'd4);
            chk("frz_dis", disabled_mask, 32'd1 << 2);
        end
        rdy       = 1'b1;
        act_valid = '0;
        flush     = 1'b0;
        tick();
        chk("frz_resume_valid", 32'(out_valid), 32'd0);
        chk("frz_resume_dis", disabled_mask, 32'h14);
        chk("frz_issue", perf_issue_cnt, PERF ? 32'd2 : 32'd0);
        chk("frz_stall", perf_stall_cnt, 32'd0);

        // Reset while holding drops the output without a disable
        out_ready = 1'b0;
        act_valid = 2'b11;
        act_warp  = {5'd4, 5'd2};
        tick();
        act_valid = '0;
        tick();
        chk("rh_valid", 32'(out_valid), 32'd1);
        chk("rh_warp", 32'(out_warp), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_drop_valid", 32'(out_valid), 32'd0);
        chk("rh_drop_dis", disabled_mask, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
